wb_mem_arbiter: RTL and testbench

Two-master Wishbone B3 arbiter sharing the single simulation memory port (`wb_m2s_mem_*` / `wb_s2m_mem_*`) between the CPU bus and a second master (debug/loader). It sits between `orpsoc_top`'s memory-side master and `wb_ram`. Grant is round-robin and held for the whole `cyc` (so bursts are never split). A watchdog aborts transfers the slave never answers.

---
 rtl/wb_mem_arbiter_pkg.sv | 23 ++
 rtl/wb_mem_arbiter_watchdog.sv | 31 +++
 rtl/wb_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone memory arbiter:
// FSM state encodings, cycle-type constants and the watchdog width helper.
package wb_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    // Wishbone B3 cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Watchdog counter width: enough to hold TIMEOUT, never narrower than 1 bit
    function automatic int wd_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_mem_arbiter_watchdog.sv
// Counts consecutive unanswered strobe cycles of the current owner and flags
// expiry on the cycle the count reaches TIMEOUT-1 with still no response.
// TIMEOUT = 0 disables expiry entirely.
module wb_mem_arbiter_watchdog
    import wb_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_expire
);

    localparam int WDW = wd_width(TIMEOUT);
    localparam logic [WDW-1:0] LIMIT = (TIMEOUT == 0) ? '0 : WDW'(TIMEOUT - 1);

    logic [WDW-1:0] r_wd;

    // Count while the owner strobes unanswered; any other cycle restarts the count
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + WDW'(1);
        end
    end

    assign o_expire = (TIMEOUT != 0) && i_run && (r_wd == LIMIT);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone B3 arbiter in front of a single memory slave port.
// Round-robin grant held for the whole cyc so bursts are never split; a
// watchdog aborts strobes the slave never answers with a one-cycle err.
// Handshake: a beat completes in any cycle where the owner's cyc and stb are
// high and the slave returns ack (or err); ack/err pass straight through to
// the owner only, and the non-owner sees neither.
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic            timeout_o,
    output arb_state_e      state_o
);

    arb_state_e r_state;
    logic       r_owner;
    logic       r_last;

    logic w_own_cyc;
    logic w_own_stb;
    logic w_oth_cyc;
    logic w_resp;
    logic w_wd_run;
    logic w_expire;
    logic w_pick;
    logic w_grant;
    logic w_abort;

    assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
    assign w_own_stb = r_owner ? m1_stb_i : m0_stb_i;
    assign w_oth_cyc = r_owner ? m0_cyc_i : m1_cyc_i;
    assign w_resp    = s_ack_i | s_err_i;
    assign w_wd_run  = (r_state == ST_GRANT) && w_own_cyc && w_own_stb && !w_resp;

    // Under contention the master that did not win last time is chosen
    assign w_pick = (m0_cyc_i && m1_cyc_i) ? ~r_last : m1_cyc_i;

    wb_mem_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_run    (w_wd_run),
        .o_expire (w_expire)
    );

    // Arbitration FSM: grant, direct hand-over on release, one-cycle abort
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                    end
                end
                ST_GRANT: begin
                    if (!w_own_cyc) begin
                        if (w_oth_cyc) begin
                            r_owner <= ~r_owner;
                            r_last  <= ~r_owner;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_expire) begin
                        r_state <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    r_state <= ST_GRANT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held so an interrupted master gets no response
    assign w_grant = (r_state == ST_GRANT) && !wb_rst_i;
    assign w_abort = (r_state == ST_ABORT) && !wb_rst_i;

    // Slave-side mux of the owner's request and owner-only response routing
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_cti_o   = '0;
        s_bte_o   = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        timeout_o = 1'b0;
        if (w_grant) begin
            s_adr_o = r_owner ? m1_adr_i : m0_adr_i;
            s_dat_o = r_owner ? m1_dat_i : m0_dat_i;
            s_sel_o = r_owner ? m1_sel_i : m0_sel_i;
            s_we_o  = r_owner ? m1_we_i  : m0_we_i;
            s_cyc_o = w_own_cyc;
            s_stb_o = w_own_stb;
            s_cti_o = r_owner ? m1_cti_i : m0_cti_i;
            s_bte_o = r_owner ? m1_bte_i : m0_bte_i;
            m0_ack_o = !r_owner && s_ack_i;
            m0_err_o = !r_owner && s_err_i;
            m1_ack_o = r_owner && s_ack_i;
            m1_err_o = r_owner && s_err_i;
        end else if (w_abort) begin
            m0_err_o  = !r_owner;
            m1_err_o  = r_owner;
            timeout_o = 1'b1;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign state_o  = r_state;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: scenario tasks with inline checks plus a
// scoreboard of expected {m1_ack, m0_ack, address} per acknowledged beat.
module tb_wb_mem_arbiter;
    import wb_mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 8;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic [AW-1:0]   m0_adr_i, m1_adr_i;
    logic [DW-1:0]   m0_dat_i, m1_dat_i;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i;
    logic            m0_we_i, m0_cyc_i, m0_stb_i;
    logic            m1_we_i, m1_cyc_i, m1_stb_i;
    logic [2:0]      m0_cti_i, m1_cti_i;
    logic [1:0]      m0_bte_i, m1_bte_i;
    logic [DW-1:0]   m0_dat_o, m1_dat_o;
    logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i;
    logic            timeout_o;
    arb_state_e      state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [AW+1:0] exp_q[$];

    wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_sel_i (m0_sel_i),
        .m0_we_i  (m0_we_i),  .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i),
        .m0_cti_i (m0_cti_i), .m0_bte_i (m0_bte_i),
        .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_sel_i (m1_sel_i),
        .m1_we_i  (m1_we_i),  .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i),
        .m1_cti_i (m1_cti_i), .m1_bte_i (m1_bte_i),
        .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),   .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),
        .s_cti_o  (s_cti_o),  .s_bte_o  (s_bte_o),
        .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i),
        .timeout_o (timeout_o), .state_o (state_o)
    );

    // Clock
    always #5 wb_clk_i = ~wb_clk_i;

    // Scoreboard: every slave ack outside reset must match the oldest expected beat
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && s_ack_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_ack: got adr %h with empty queue", s_adr_o);
            end else begin
                logic [AW+1:0] exp_v;
                exp_v = exp_q.pop_front();
                if ({m1_ack_o, m0_ack_o, s_adr_o} !== exp_v)
                    $display("FAIL sb_beat: got %h expected %h", {m1_ack_o, m0_ack_o, s_adr_o}, exp_v);
                else
                    n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drive_idle();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = CTI_CLASSIC; m0_bte_i = 2'b00;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cti_i = CTI_CLASSIC; m1_bte_i = 2'b00;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    endtask

    task automatic m0_req(input logic [AW-1:0] adr, input logic [2:0] cti);
        m0_adr_i = adr; m0_cti_i = cti; m0_sel_i = '1; m0_we_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    endtask

    task automatic m1_req(input logic [AW-1:0] adr, input logic [2:0] cti);
        m1_adr_i = adr; m1_cti_i = cti; m1_sel_i = '1; m1_we_i = 1'b0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    endtask

    task automatic pulse_reset();
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        wb_rst_i = 1'b1;
        m0_req(32'h0000_0010, CTI_CLASSIC);
        s_dat_i = 32'hCAFE_0001;
        s_ack_i = 1'b1;
        step();
        step();
        n_checks++;
        if ({s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o} !== 7'b0)
            $display("FAIL reset_outputs: got %b expected 0",
                     {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o});
        else n_pass++;
        n_checks++;
        if (state_o !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", state_o, ST_IDLE);
        else n_pass++;
        n_checks++;
        if (m0_dat_o !== 32'hCAFE_0001) $display("FAIL reset_dat_follow: got %h expected %h", m0_dat_o, 32'hCAFE_0001);
        else n_pass++;
        drive_idle();
        wb_rst_i = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        logic [DW-1:0] d;
        d = 32'($urandom_range(0, 32'h7FFF_FFFF));
        m0_req(32'h0000_0100, CTI_CLASSIC);
        n_checks++;
        if (s_cyc_o !== 1'b0) $display("FAIL single_idle_gap: got %b expected 0", s_cyc_o);
        else n_pass++;
        step();
        n_checks++;
        if ({s_cyc_o, s_stb_o, s_adr_o} !== {2'b11, 32'h0000_0100})
            $display("FAIL single_grant: got %h expected %h", {s_cyc_o, s_stb_o, s_adr_o}, {2'b11, 32'h0000_0100});
        else n_pass++;
        step();
        s_ack_i = 1'b1; s_dat_i = d;
        exp_q.push_back({2'b01, 32'h0000_0100});
        #1;
        n_checks++;
        if ({m0_ack_o, m1_ack_o, m0_dat_o} !== {2'b10, d})
            $display("FAIL single_ack: got %h expected %h", {m0_ack_o, m1_ack_o, m0_dat_o}, {2'b10, d});
        else n_pass++;
        step();
        drive_idle();
        step();
        n_checks++;
        if (state_o !== ST_IDLE) $display("FAIL single_release: got %0d expected %0d", state_o, ST_IDLE);
        else n_pass++;
    endtask

    task automatic test_contention();
        pulse_reset();
        m0_req(32'h0000_0200, CTI_CLASSIC);
        m1_req(32'h0000_0300, CTI_CLASSIC);
        step();
        s_ack_i = 1'b1; s_dat_i = 32'($urandom_range(0, 65535));
        exp_q.push_back({2'b01, 32'h0000_0200});
        #1;
        n_checks++;
        if (s_adr_o !== 32'h0000_0200) $display("FAIL contention_first: got %h expected %h", s_adr_o, 32'h0000_0200);
        else n_pass++;
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        n_checks++;
        if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h0000_0300})
            $display("FAIL handover_no_gap: got %h expected %h", {s_cyc_o, s_adr_o}, {1'b1, 32'h0000_0300});
        else n_pass++;
        s_ack_i = 1'b1;
        exp_q.push_back({2'b10, 32'h0000_0300});
        #1;
        n_checks++;
        if ({m1_ack_o, m0_ack_o} !== 2'b10) $display("FAIL handover_ack_route: got %b expected 10", {m1_ack_o, m0_ack_o});
        else n_pass++;
        step();
        drive_idle();
        step();
        m0_req(32'h0000_0204, CTI_CLASSIC);
        m1_req(32'h0000_0304, CTI_CLASSIC);
        step();
        s_ack_i = 1'b1;
        exp_q.push_back({2'b01, 32'h0000_0204});
        #1;
        n_checks++;
        if (s_adr_o !== 32'h0000_0204) $display("FAIL contention_second: got %h expected %h", s_adr_o, 32'h0000_0204);
        else n_pass++;
        step();
        drive_idle();
        step();
        step();
    endtask

    task automatic test_burst_lock();
        m1_req(32'h0000_0400, CTI_INCR);
        step();
        m0_req(32'h0000_0500, CTI_CLASSIC);
        for (int k = 0; k < 4; k++) begin
            m1_adr_i = 32'h0000_0400 + 32'(4 * k);
            m1_cti_i = (k == 3) ? CTI_EOB : CTI_INCR;
            s_ack_i = 1'b1; s_dat_i = 32'($urandom_range(0, 65535));
            exp_q.push_back({2'b10, m1_adr_i});
            #1;
            n_checks++;
            if ({m0_ack_o, s_cti_o} !== {1'b0, m1_cti_i})
                $display("FAIL burst_beat%0d: got %h expected %h", k, {m0_ack_o, s_cti_o}, {1'b0, m1_cti_i});
            else n_pass++;
            step();
        end
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        n_checks++;
        if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h0000_0500})
            $display("FAIL burst_then_m0: got %h expected %h", {s_cyc_o, s_adr_o}, {1'b1, 32'h0000_0500});
        else n_pass++;
        s_ack_i = 1'b1;
        exp_q.push_back({2'b01, 32'h0000_0500});
        step();
        drive_idle();
        step();
        step();
    endtask

    task automatic test_timeout();
        m0_req(32'h0000_0600, CTI_CLASSIC);
        step();
        for (int i = 0; i < TIMEOUT; i++) begin
            n_checks++;
            if ({s_stb_o, timeout_o, m0_err_o} !== 3'b100)
                $display("FAIL timeout_wait%0d: got %b expected 100", i, {s_stb_o, timeout_o, m0_err_o});
            else n_pass++;
            step();
        end
        n_checks++;
        if ({s_cyc_o, s_stb_o, m0_err_o, m1_err_o, timeout_o} !== 5'b00101)
            $display("FAIL timeout_abort: got %b expected 00101", {s_cyc_o, s_stb_o, m0_err_o, m1_err_o, timeout_o});
        else n_pass++;
        step();
        n_checks++;
        if ({state_o, s_stb_o, timeout_o, m0_err_o} !== {ST_GRANT, 3'b100})
            $display("FAIL timeout_regrant: got %b expected %b", {state_o, s_stb_o, timeout_o, m0_err_o}, {ST_GRANT, 3'b100});
        else n_pass++;
        drive_idle();
        step();
        step();
    endtask

    task automatic test_race();
        m0_req(32'h0000_0640, CTI_CLASSIC);
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        s_ack_i = 1'b1;
        exp_q.push_back({2'b01, 32'h0000_0640});
        #1;
        n_checks++;
        if ({m0_ack_o, m0_err_o, timeout_o} !== 3'b100)
            $display("FAIL race_ack: got %b expected 100", {m0_ack_o, m0_err_o, timeout_o});
        else n_pass++;
        step();
        s_ack_i = 1'b0;
        #1;
        n_checks++;
        if ({state_o, timeout_o} !== {ST_GRANT, 1'b0})
            $display("FAIL race_no_abort: got %b expected %b", {state_o, timeout_o}, {ST_GRANT, 1'b0});
        else n_pass++;
        drive_idle();
        step();
        step();
    endtask

    task automatic test_reset_mid_burst();
        m0_req(32'h0000_0700, CTI_INCR);
        step();
        s_ack_i = 1'b1;
        exp_q.push_back({2'b01, 32'h0000_0700});
        step();
        m0_adr_i = 32'h0000_0704;
        wb_rst_i = 1'b1;
        #1;
        n_checks++;
        if ({m0_ack_o, m0_err_o} !== 2'b00) $display("FAIL rst_burst_no_resp: got %b expected 00", {m0_ack_o, m0_err_o});
        else n_pass++;
        step();
        wb_rst_i = 1'b0; s_ack_i = 1'b0;
        #1;
        n_checks++;
        if ({s_cyc_o, m0_ack_o, m0_err_o, timeout_o} !== 4'b0000)
            $display("FAIL rst_burst_quiet: got %b expected 0000", {s_cyc_o, m0_ack_o, m0_err_o, timeout_o});
        else n_pass++;
        m1_req(32'h0000_0800, CTI_CLASSIC);
        step();
        n_checks++;
        if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h0000_0704})
            $display("FAIL rst_then_m0_wins: got %h expected %h", {s_cyc_o, s_adr_o}, {1'b1, 32'h0000_0704});
        else n_pass++;
        drive_idle();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_burst_lock();
        test_timeout();
        test_race();
        test_reset_mid_burst();
        step();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
